// File: rtl/fifo_read_ctrl_pkg.sv
// Shared definitions for the async FIFO read side: data/address sizes,
// read-controller state encoding and the FIFO read latency.
package definitions;

  localparam int DATASIZE = 8;
  localparam int ADDRSIZE = 4;

  // Cycles from ren to rack/rdata on the FIFO read port
  localparam int RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } read_state_t;

endpackage

// File: rtl/fifo_read_ctrl_skid_buf.sv
// Small synchronous FIFO used as the skid buffer behind the FIFO read port.
// The controller guarantees push never hits a full buffer and pop never an empty one.
module rd_skid_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     occ,
  output logic [W-1:0]               head
);

  localparam int PTRW = $clog2(DEPTH);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW:0]   occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
    if (push && !pop) begin
      occ_d = occ_q + (PTRW+1)'(1);
    end else if (!push && pop) begin
      occ_d = occ_q - (PTRW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is not cleared; the head is only meaningful while occ != 0
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= push_data;
  end

  assign occ  = occ_q;
  assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side consumer for the async FIFO: issues ren under a credit scheme,
// captures rack-qualified data into a skid buffer and streams it out.
module fifo_read_ctrl #(
  parameter int DATASIZE  = definitions::DATASIZE,
  parameter int BUF_DEPTH = 2,
  parameter int COUNTW    = 16
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rd_enable,
  input  logic                ridle,
  input  logic                remty,
  input  logic                rack,
  input  logic [DATASIZE-1:0] rdata,
  output logic                ren,
  output logic                out_valid,
  output logic [DATASIZE-1:0] out_data,
  input  logic                out_ready,
  output logic [COUNTW-1:0]   rd_count,
  output logic                err_unexp_ack,
  output logic                err_no_ack
);

  import definitions::*;

  localparam int OCCW = $clog2(BUF_DEPTH) + 1;

  read_state_t         state_q, state_d;
  logic [RD_LAT-1:0]   pipe_q, pipe_d;
  logic                first_q;
  logic [COUNTW-1:0]   rd_count_q, rd_count_d;
  logic                err_unexp_q, err_unexp_d;
  logic                err_noack_q, err_noack_d;

  logic [OCCW-1:0]     occ;
  logic [DATASIZE-1:0] head;
  logic [OCCW:0]       used;
  logic                inflight, has_credit, issue, ren_c;
  logic                pop, accept, unexp, noack;

  assign inflight  = pipe_q[RD_LAT-1];
  assign out_valid = (occ != '0);
  assign pop       = out_valid & out_ready;

  // A word leaving the buffer this cycle frees its slot for a read issued now,
  // which is what keeps back-to-back reads going with a two-entry buffer.
  always_comb begin
    used = (OCCW+1)'(occ) + (OCCW+1)'($countones(pipe_q)) - (OCCW+1)'(pop);
  end

  assign has_credit = (used < (OCCW+1)'(BUF_DEPTH));
  assign issue      = rd_enable & ~remty & has_credit;

  always_comb begin
    state_d = state_q;
    ren_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) state_d = READ;
      end
      READ: begin
        ren_c = issue;
        if (issue && ridle) begin
          state_d = GAP;
        end else if (!rd_enable || remty) begin
          state_d = IDLE;
        end
      end
      GAP: begin
        state_d = issue ? READ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A stray rack in the first cycle out of reset belongs to a pre-reset read
  assign accept = rack & inflight;
  assign unexp  = rack & ~inflight & ~first_q;
  assign noack  = inflight & ~rack;

  always_comb begin
    pipe_d      = RD_LAT'({pipe_q, ren_c});
    rd_count_d  = rd_count_q + COUNTW'(accept);
    err_unexp_d = err_unexp_q | unexp;
    err_noack_d = err_noack_q | noack;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q     <= IDLE;
      pipe_q      <= '0;
      first_q     <= 1'b1;
      rd_count_q  <= '0;
      err_unexp_q <= 1'b0;
      err_noack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pipe_q      <= pipe_d;
      first_q     <= 1'b0;
      rd_count_q  <= rd_count_d;
      err_unexp_q <= err_unexp_d;
      err_noack_q <= err_noack_d;
    end
  end

  rd_skid_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (DATASIZE)
  ) u_skid (
    .clk       (rclk),
    .clr       (rrst),
    .push      (accept),
    .push_data (rdata),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

  assign ren           = ren_c;
  assign out_data      = out_valid ? head : '0;
  assign rd_count      = rd_count_q;
  assign err_unexp_ack = err_unexp_q;
  assign err_no_ack    = err_noack_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a one-cycle-latency FIFO responder
// driven from the stimulus process.
module tb_fifo_read_ctrl;

  logic        rclk = 1'b0;
  logic        rrst, rd_enable, ridle, remty, rack, out_ready;
  logic [7:0]  rdata, out_data;
  logic        ren, out_valid, err_unexp_ack, err_no_ack;
  logic [15:0] rd_count;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  fifo_mem [16];
  int          rd_n, wr_n, step_n, first_pop;
  bit          drop_ack, inj_ack, verbose;
  logic [63:0] ren_hist;
  logic [7:0]  got [$];

  always #5 rclk = ~rclk;

  fifo_read_ctrl #(
    .DATASIZE  (8),
    .BUF_DEPTH (2),
    .COUNTW    (16)
  ) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .rd_enable     (rd_enable),
    .ridle         (ridle),
    .remty         (remty),
    .rack          (rack),
    .rdata         (rdata),
    .ren           (ren),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .rd_count      (rd_count),
    .err_unexp_ack (err_unexp_ack),
    .err_no_ack    (err_no_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; entered and left at the falling edge.
  task automatic step();
    logic ren_s;
    #1;
    ren_s    = ren;
    ren_hist = {ren_hist[62:0], ren_s};
    if (out_valid === 1'b1 && out_ready) begin
      got.push_back(out_data);
      if (first_pop < 0) first_pop = step_n;
      if (verbose) $display("t=%0t pop data=%02h rd_count=%0d", $time, out_data, rd_count);
    end
    @(posedge rclk);
    #1;
    rack = 1'b0;
    if (ren_s === 1'b1) begin
      if (drop_ack) begin
        drop_ack = 1'b0;
      end else begin
        rack  = 1'b1;
        rdata = fifo_mem[rd_n % 16];
      end
      rd_n++;
    end
    if (inj_ack) rack = 1'b1;
    remty = (rd_n >= wr_n);
    step_n++;
    @(negedge rclk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rrst = 1'b1; rd_enable = 1'b0; ridle = 1'b0; out_ready = 1'b0;
    drop_ack = 1'b0; inj_ack = 1'b0;
    rd_n = 0; wr_n = 0; remty = 1'b1;
    step();
    step();
    rrst = 1'b0;
    got.delete();
    ren_hist = '0; step_n = 0; first_pop = -1;
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_mem[i] = base + 8'(i);
    wr_n = n; rd_n = 0; remty = 1'b0;
  endtask

  function automatic logic [63:0] got_word();
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < got.size() && i < 8; i++) w = {w[55:0], got[i]};
    return w;
  endfunction

  initial begin
    rrst = 1'b1; rd_enable = 1'b0; ridle = 1'b0; remty = 1'b1;
    rack = 1'b0; rdata = '0; out_ready = 1'b0; verbose = 1'b1;
    drop_ack = 1'b0; inj_ack = 1'b0;
    @(negedge rclk);

    // Reset state
    do_reset();
    chk("rst_ren", 64'(ren), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_rd_count", 64'(rd_count), 64'h0);
    chk("rst_errs", 64'({err_unexp_ack, err_no_ack}), 64'h0);

    // Full-throughput burst of four words
    $display("burst ridle=0");
    load(8'hA1, 4);
    rd_enable = 1'b1; out_ready = 1'b1;
    run(10);
    chk("t1_ren_pattern", 64'(ren_hist[9:0]), 64'h1E0);
    chk("t1_first_pop_cycle", 64'(first_pop), 64'd3);
    chk("t1_out_seq", got_word(), 64'hA1A2A3A4);
    chk("t1_rd_count", 64'(rd_count), 64'd4);
    chk("t1_errs", 64'({err_unexp_ack, err_no_ack}), 64'h0);
    chk("t1_drained", 64'(out_valid), 64'h0);

    // Same data with a gap after every read
    $display("burst ridle=1");
    do_reset();
    load(8'hA1, 4);
    rd_enable = 1'b1; out_ready = 1'b1; ridle = 1'b1;
    run(12);
    chk("t2_ren_pattern", 64'(ren_hist[11:0]), 64'h550);
    chk("t2_out_seq", got_word(), 64'hA1A2A3A4);
    chk("t2_rd_count", 64'(rd_count), 64'd4);

    // Back-pressure: only the buffer depth is fetched, head held stable
    $display("back-pressure");
    do_reset();
    load(8'hB1, 5);
    rd_enable = 1'b1; out_ready = 1'b0;
    run(8);
    chk("t3_ren_pattern", 64'(ren_hist[7:0]), 64'h60);
    chk("t3_rd_count_held", 64'(rd_count), 64'd2);
    chk("t3_valid_held", 64'(out_valid), 64'h1);
    chk("t3_head_held", 64'(out_data), 64'hB1);
    run(3);
    chk("t3_head_stable", 64'(out_data), 64'hB1);
    chk("t3_ren_stalled", 64'(ren), 64'h0);
    out_ready = 1'b1;
    ren_hist = '0;
    run(12);
    chk("t3_release_ren", 64'(ren_hist[11:0]), 64'hE00);
    chk("t3_out_seq", got_word(), 64'hB1B2B3B4B5);
    chk("t3_rd_count", 64'(rd_count), 64'd5);

    // Protocol errors
    $display("protocol errors");
    do_reset();
    step();
    inj_ack = 1'b1;
    step();
    inj_ack = 1'b0;
    step();
    chk("t4_unexp_set", 64'(err_unexp_ack), 64'h1);
    chk("t4_noack_clear", 64'(err_no_ack), 64'h0);
    step();
    chk("t4_unexp_sticky", 64'(err_unexp_ack), 64'h1);
    load(8'hC1, 2);
    drop_ack = 1'b1; rd_enable = 1'b1; out_ready = 1'b1;
    ren_hist = '0;
    run(8);
    chk("t4_ren_pattern", 64'(ren_hist[7:0]), 64'h60);
    chk("t4_noack_set", 64'(err_no_ack), 64'h1);
    chk("t4_rd_count", 64'(rd_count), 64'd1);
    chk("t4_later_data", got_word(), 64'hC2);
    chk("t4_unexp_still", 64'(err_unexp_ack), 64'h1);

    // Reset in the middle of a burst
    $display("reset mid-burst");
    do_reset();
    load(8'hD1, 4);
    rd_enable = 1'b1; out_ready = 1'b1;
    run(3);
    chk("t5_pre_valid", 64'(out_valid), 64'h1);
    chk("t5_pre_ren", 64'(ren), 64'h1);
    rrst = 1'b1;
    step();
    rrst = 1'b0; rd_enable = 1'b0;
    chk("t5_ren", 64'(ren), 64'h0);
    chk("t5_out_valid", 64'(out_valid), 64'h0);
    chk("t5_out_data", 64'(out_data), 64'h0);
    chk("t5_rd_count", 64'(rd_count), 64'h0);
    chk("t5_trailing_rack", 64'(rack), 64'h1);
    step();
    chk("t5_no_errs", 64'({err_unexp_ack, err_no_ack}), 64'h0);
    chk("t5_rd_count_after", 64'(rd_count), 64'h0);
    chk("t5_valid_after", 64'(out_valid), 64'h0);

    // Counter wrap after 65536 accepted words
    $display("counter wrap");
    do_reset();
    for (int i = 0; i < 16; i++) fifo_mem[i] = 8'(i);
    wr_n = 65536; rd_n = 0; remty = 1'b0;
    rd_enable = 1'b1; out_ready = 1'b1; verbose = 1'b0;
    for (int i = 0; i < 70000 && rd_count !== 16'hFFFF; i++) step();
    chk("t6_count_ffff", 64'(rd_count), 64'hFFFF);
    run(6);
    verbose = 1'b1;
    chk("t6_count_wrap", 64'(rd_count), 64'h0);
    chk("t6_drained", 64'(out_valid), 64'h0);
    chk("t6_errs", 64'({err_unexp_ack, err_no_ack}), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
